decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered MIPS instruction-decode stage with a valid/ready handshake on both sides.
- Decodes the integer subset plus LUI/JAL, and extracts register addresses and the extended immediate.
- Detects load-use hazards against the instruction it holds and inserts one bubble per hazard.
- Sits between the IF/ID boundary and EX; flushable by branch/jump resolution.

Parameters:
ALUCODE_W, 5, width of the ALU operation code.
CNT_W, 16, width of the saturating load-use stall counter.
EXT_OPS, 1, 1 = decode LUI and JAL; 0 = treat them as illegal.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held and incoming instruction
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage accepts in_instr this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  32  registered pc
out_alu_code  out  ALUCODE_W  ALU operation
out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  datapath enables
out_alu_src_a  out  1  1 = shamt is operand A
out_alu_src_b  out  1  1 = immediate is operand B
out_j, out_jr, out_jal, out_branch, out_lui  out  1 each  control-flow and LUI class flags
out_illegal  out  1  undefined encoding
out_rs, out_rt, out_dest  out  5 each  source registers and resolved destination register
out_imm  out  32  extended immediate
stall_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset: every output register is 0, including out_valid and stall_cnt. in_ready is combinational.
- Latency: 1 cycle. A bundle is accepted on the in_valid & in_ready edge and presented on the next cycle.
- Handshake:
  - in_ready = flush | ((!out_valid | out_ready) & !hazard).
  - The output holds stable while out_valid & !out_ready.
  - out_valid drops only when out_ready is high or on flush.
- hazard = in_valid & out_valid & out_mem_read & out_dest != 0 & (uses_rs(in_instr) & rs == out_dest | uses_rt(in_instr) & rt == out_dest).
  - uses_rs: all instructions except J, JAL, LUI, SLL/SRL/SRA and NOP.
  - uses_rt: R-type, BEQ, BNE, SW.
- Hazard with out_ready = 1: the held load leaves, out_valid <= 0 (bubble), the input is not taken, and stall_cnt increments (saturating at all-ones). The next cycle accepts normally.
- Hazard with out_ready = 0: hold; no count.
- flush has the highest priority. On the next edge out_valid <= 0, the incoming beat is consumed and discarded, and there is no count.
- rst_n falling mid-operation clears everything immediately, with no handshake completion.
- Decode rules:
  - R-type reg-reg ops (ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLLV/SRLV/SRAV): reg_write, dest = rd.
  - SLL/SRL/SRA: additionally alu_src_a = 1.
  - The all-zero word is a NOP: valid with no enables and illegal = 0.
  - I-type ALU ops (ADDI/ADDIU/SLTI/SLTIU): sign-extend; ANDI/ORI/XORI: zero-extend. All set alu_src_b = 1, reg_write, dest = rt.
  - LW: mem_read, mem_to_reg, reg_write, dest = rt, alu_code = add.
  - SW: mem_write, alu_code = add, dest = 0.
  - BEQ/BNE/BGTZ/BLEZ: branch. REGIMM (op 000001) distinguishes BLTZ (rt 00000) from BGEZ (rt 00001); any other rt is illegal. Branch imm = sign-extended offset shifted left by 2.
  - J: j = 1, imm = {4'b0, target, 2'b00}.
  - JR: jr = 1.
  - JAL: jal, reg_write, dest = 31, same imm as J.
  - LUI: lui, reg_write, dest = rt, imm = {imm16, 16'b0}, alu_src_b = 1.
- Any other op/funct: illegal = 1, all enables 0, alu_code = 0. The bundle still flows, so EX raises the exception.
- dest is forced to 0 whenever reg_write = 0.

Decomposition:
- Package decode_pkg holds:
  - opcode and funct constants;
  - ALU codes: add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101, andi 00110, xori 00111, ori 01000, jr 01001, beq 01010, bne 01011, bgez 01100, bgtz 01101, blez 01110, bltz 01111, sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100, lui 10101;
  - the control-bundle struct.
- Sub-module decode_comb: purely combinational instruction-to-bundle logic, including uses_rs/uses_rt.
- The top module holds the register, handshake, hazard logic and counter.

Test Plan:
- Reset, then drive ADDI $8,$0,-1 (0x2008FFFF) with out_ready = 1 → after 1 cycle: out_valid = 1, out_imm = 0xFFFFFFFF, dest = 8, alu_src_b = 1, alu_code = 00000.
- Drive LW $9,0($8) then ADD $10,$9,$9 back-to-back → one bubble cycle (out_valid = 0), in_ready low for 1 cycle, stall_cnt = 1; ADD appears on the following cycle.
- Hold out_ready = 0 for 3 cycles with ORI presented → out bundle stable and in_ready = 0 throughout; release → transfer in 1 cycle.
- Assert flush with a valid held instruction and a valid input → next cycle out_valid = 0, stall_cnt unchanged.
- Drive 0x04110004 (REGIMM, rt = 10001) → out_illegal = 1, reg_write = 0. Drive 0x04010004 → branch = 1, alu_code = 01100, imm = 0x10.
- Drive JAL 0x0C000010 → jal = 1, dest = 31, imm = 0x40. Same word with EXT_OPS = 0 → illegal = 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants and the decoded control bundle carried from ID to EX.
// Opcode/funct values follow the classic MIPS-I encoding.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int ALU_W = 5;

  localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_NOR  = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_ANDI = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_XORI = 5'b00111;
  localparam logic [ALU_W-1:0] ALU_ORI  = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_JR   = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_BEQ  = 5'b01010;
  localparam logic [ALU_W-1:0] ALU_BNE  = 5'b01011;
  localparam logic [ALU_W-1:0] ALU_BGEZ = 5'b01100;
  localparam logic [ALU_W-1:0] ALU_BGTZ = 5'b01101;
  localparam logic [ALU_W-1:0] ALU_BLEZ = 5'b01110;
  localparam logic [ALU_W-1:0] ALU_BLTZ = 5'b01111;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'b10001;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'b10010;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'b10011;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'b10100;
  localparam logic [ALU_W-1:0] ALU_LUI  = 5'b10101;

  typedef struct packed {
    logic [ALU_W-1:0] alu_code;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic             alu_src_b;
    logic             j;
    logic             jr;
    logic             jal;
    logic             branch;
    logic             lui;
    logic             illegal;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       dest;
    logic [31:0]      imm;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID-side and ID/EX-side handshake plus the decoded bundle; slave is the stage's view.
interface decode_stage_if #(
  parameter int ALUCODE_W = 5
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [31:0]          in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic [ALUCODE_W-1:0] out_alu_code;
  logic                 out_reg_write;
  logic                 out_mem_read;
  logic                 out_mem_write;
  logic                 out_mem_to_reg;
  logic                 out_alu_src_a;
  logic                 out_alu_src_b;
  logic                 out_j;
  logic                 out_jr;
  logic                 out_jal;
  logic                 out_branch;
  logic                 out_lui;
  logic                 out_illegal;
  logic [4:0]           out_rs;
  logic [4:0]           out_rt;
  logic [4:0]           out_dest;
  logic [31:0]          out_imm;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_code, out_reg_write, out_mem_read,
           out_mem_write, out_mem_to_reg, out_alu_src_a, out_alu_src_b, out_j, out_jr,
           out_jal, out_branch, out_lui, out_illegal, out_rs, out_rt, out_dest, out_imm
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_code, out_reg_write, out_mem_read,
           out_mem_write, out_mem_to_reg, out_alu_src_a, out_alu_src_b, out_j, out_jr,
           out_jal, out_branch, out_lui, out_illegal, out_rs, out_rt, out_dest, out_imm
  );

endinterface

// File: rtl/decode_comb.sv
// Combinational instruction-to-control-bundle decode, plus register-use flags for hazard checks.
// Zero latency; no state, no backpressure.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs,
  output logic        uses_rt
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] imm_br;
  logic [31:0] imm_jmp;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign fn       = instr[5:0];
  assign imm_sext = sext16(instr[15:0]);
  assign imm_zext = {16'd0, instr[15:0]};
  assign imm_br   = {imm_sext[29:0], 2'b00};
  assign imm_jmp  = {4'd0, instr[25:0], 2'b00};

  // Classified by encoding alone so the hazard check does not depend on legality.
  assign uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI) ||
                     ((op == OP_RTYPE) && ((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA))));
  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

  always_comb begin
    ctrl    = '0;
    ctrl.rs = rs;
    ctrl.rt = rt;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.dest      = rd;
        case (fn)
          FN_ADD, FN_ADDU: ctrl.alu_code = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_code = ALU_SUB;
          FN_AND:          ctrl.alu_code = ALU_AND;
          FN_OR:           ctrl.alu_code = ALU_OR;
          FN_XOR:          ctrl.alu_code = ALU_XOR;
          FN_NOR:          ctrl.alu_code = ALU_NOR;
          FN_SLT:          ctrl.alu_code = ALU_SLT;
          FN_SLTU:         ctrl.alu_code = ALU_SLTU;
          FN_SLLV:         ctrl.alu_code = ALU_SLL;
          FN_SRLV:         ctrl.alu_code = ALU_SRL;
          FN_SRAV:         ctrl.alu_code = ALU_SRA;
          FN_SLL: begin
            ctrl.alu_code  = ALU_SLL;
            ctrl.alu_src_a = 1'b1;
          end
          FN_SRL: begin
            ctrl.alu_code  = ALU_SRL;
            ctrl.alu_src_a = 1'b1;
          end
          FN_SRA: begin
            ctrl.alu_code  = ALU_SRA;
            ctrl.alu_src_a = 1'b1;
          end
          FN_JR: begin
            ctrl.alu_code  = ALU_JR;
            ctrl.jr        = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          default: ctrl.illegal = 1'b1;
        endcase
        // Shift-by-immediate carries shamt to EX in the immediate field.
        if (ctrl.alu_src_a) ctrl.imm = {27'd0, shamt};
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.dest      = rt;
        ctrl.imm       = imm_sext;
        ctrl.alu_code  = (op == OP_SLTI)  ? ALU_SLT :
                         (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.dest      = rt;
        ctrl.imm       = imm_zext;
        ctrl.alu_code  = (op == OP_ANDI) ? ALU_ANDI :
                         (op == OP_ORI)  ? ALU_ORI  : ALU_XORI;
      end
      OP_LW: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.dest       = rt;
        ctrl.imm        = imm_sext;
        ctrl.alu_code   = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm       = imm_sext;
        ctrl.alu_code  = ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch   = 1'b1;
        ctrl.imm      = imm_br;
        ctrl.alu_code = (op == OP_BEQ)  ? ALU_BEQ  :
                        (op == OP_BNE)  ? ALU_BNE  :
                        (op == OP_BLEZ) ? ALU_BLEZ : ALU_BGTZ;
      end
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          ctrl.branch   = 1'b1;
          ctrl.imm      = imm_br;
          ctrl.alu_code = rt[0] ? ALU_BGEZ : ALU_BLTZ;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_J: begin
        ctrl.j   = 1'b1;
        ctrl.imm = imm_jmp;
      end
      OP_JAL: begin
        if (EXT_OPS) begin
          ctrl.jal       = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = 5'd31;
          ctrl.imm       = imm_jmp;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT_OPS) begin
          ctrl.lui       = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_src_b = 1'b1;
          ctrl.dest      = rt;
          ctrl.imm       = {instr[15:0], 16'd0};
          ctrl.alu_code  = ALU_LUI;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase

    if (instr == 32'd0) begin
      ctrl = '0;
    end
    // Illegal words still flow so EX can raise the exception; only the fields are kept.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      ctrl.rs      = rs;
      ctrl.rt      = rt;
    end
    if (!ctrl.reg_write) ctrl.dest = 5'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: 1-cycle latency, holds while EX stalls, one bubble per load-use hazard.
// Flush kills the held bundle and swallows the incoming beat.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ALUCODE_W = 5,
  parameter int CNT_W     = 16,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t       dec;
  ctrl_t       hold;
  logic [31:0] hold_pc;
  logic        hold_vld;
  logic        uses_rs;
  logic        uses_rt;
  logic        hazard;
  logic        take;

  decode_comb #(
    .EXT_OPS(EXT_OPS)
  ) u_comb (
    .instr  (bus.in_instr),
    .ctrl   (dec),
    .uses_rs(uses_rs),
    .uses_rt(uses_rt)
  );

  // The held load's result is not available to EX for the instruction right behind it.
  assign hazard = bus.in_valid & hold_vld & hold.mem_read & (hold.dest != 5'd0) &
                  ((uses_rs & (dec.rs == hold.dest)) | (uses_rt & (dec.rt == hold.dest)));

  assign bus.in_ready = bus.flush | ((~hold_vld | bus.out_ready) & ~hazard);
  assign take         = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold      <= '0;
      hold_pc   <= 32'd0;
      stall_cnt <= '0;
    end else if (bus.flush) begin
      hold_vld <= 1'b0;
    end else if (hazard && bus.out_ready) begin
      hold_vld <= 1'b0;
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (take) begin
      hold_vld <= 1'b1;
      hold     <= dec;
      hold_pc  <= bus.in_pc;
    end else if (bus.out_ready) begin
      hold_vld <= 1'b0;
    end
  end

  assign bus.out_valid      = hold_vld;
  assign bus.out_pc         = hold_pc;
  assign bus.out_alu_code   = ALUCODE_W'(hold.alu_code);
  assign bus.out_reg_write  = hold.reg_write;
  assign bus.out_mem_read   = hold.mem_read;
  assign bus.out_mem_write  = hold.mem_write;
  assign bus.out_mem_to_reg = hold.mem_to_reg;
  assign bus.out_alu_src_a  = hold.alu_src_a;
  assign bus.out_alu_src_b  = hold.alu_src_b;
  assign bus.out_j          = hold.j;
  assign bus.out_jr         = hold.jr;
  assign bus.out_jal        = hold.jal;
  assign bus.out_branch     = hold.branch;
  assign bus.out_lui        = hold.lui;
  assign bus.out_illegal    = hold.illegal;
  assign bus.out_rs         = hold.rs;
  assign bus.out_rt         = hold.rt;
  assign bus.out_dest       = hold.dest;
  assign bus.out_imm        = hold.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized checks of decode_stage against a table-driven reference model.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.ALUCODE_W(5)) bus ();
  decode_stage_if #(.ALUCODE_W(5)) bus2 ();
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  decode_stage #(.ALUCODE_W(5), .CNT_W(16), .EXT_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt)
  );
  decode_stage #(.ALUCODE_W(5), .CNT_W(2), .EXT_OPS(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .stall_cnt(stall_cnt2)
  );

  typedef struct packed {
    logic [4:0]  alu;
    logic        rw, mr, mw, m2r, sa, sb, j, jr, jal, br, lui, ill;
    logic [4:0]  rs, rt, dest;
    logic [31:0] imm;
  } exp_t;

  localparam int C_RR = 0, C_SH = 1, C_IS = 2, C_IZ = 3, C_LW = 4, C_SW = 5;
  localparam int C_BR = 6, C_J = 7, C_JR = 8, C_JAL = 9, C_LUI = 10;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] alu;
    int         cls;
  } ent_t;
  ent_t tbl[$];

  int          total = 0;
  int          bad = 0;
  logic        m_vld;
  exp_t        m_b;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        last_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_ent(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] alu, input int cls);
    ent_t e;
    e.op = op; e.fn = fn; e.alu = alu; e.cls = cls;
    tbl.push_back(e);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input bit ext);
    exp_t        e;
    logic [31:0] se;
    int          cls;
    e   = '0;
    cls = -1;
    e.rs = w[25:21];
    e.rt = w[20:16];
    if (w == 32'd0) return e;
    se = {{16{w[15]}}, w[15:0]};
    foreach (tbl[k])
      if (tbl[k].op == w[31:26] && (tbl[k].op != 6'd0 || tbl[k].fn == w[5:0])) begin
        cls   = tbl[k].cls;
        e.alu = tbl[k].alu;
      end
    if (w[31:26] == 6'd1 && w[20:16] <= 5'd1) begin
      cls   = C_BR;
      e.alu = w[16] ? 5'b01100 : 5'b01111;
    end
    if (!ext && (cls == C_JAL || cls == C_LUI)) cls = -1;
    case (cls)
      C_RR:  begin e.rw = 1; e.dest = w[15:11]; end
      C_SH:  begin e.rw = 1; e.sa = 1; e.dest = w[15:11]; e.imm = {27'd0, w[10:6]}; end
      C_IS:  begin e.rw = 1; e.sb = 1; e.dest = w[20:16]; e.imm = se; end
      C_IZ:  begin e.rw = 1; e.sb = 1; e.dest = w[20:16]; e.imm = {16'd0, w[15:0]}; end
      C_LW:  begin e.rw = 1; e.mr = 1; e.m2r = 1; e.sb = 1; e.dest = w[20:16]; e.imm = se; end
      C_SW:  begin e.mw = 1; e.sb = 1; e.imm = se; end
      C_BR:  begin e.br = 1; e.imm = se << 2; end
      C_J:   begin e.j = 1; e.imm = {4'd0, w[25:0], 2'd0}; end
      C_JR:  e.jr = 1;
      C_JAL: begin e.jal = 1; e.rw = 1; e.dest = 5'd31; e.imm = {4'd0, w[25:0], 2'd0}; end
      C_LUI: begin e.lui = 1; e.rw = 1; e.sb = 1; e.dest = w[20:16]; e.imm = {w[15:0], 16'd0}; end
      default: begin
        e     = '0;
        e.ill = 1;
        e.rs  = w[25:21];
        e.rt  = w[20:16];
      end
    endcase
    return e;
  endfunction

  function automatic bit ref_uses_rs(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return !(op == 6'h02 || op == 6'h03 || op == 6'h0F ||
             (op == 6'h00 && (w[5:0] == 6'h00 || w[5:0] == 6'h02 || w[5:0] == 6'h03)));
  endfunction

  function automatic bit ref_uses_rt(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
  endfunction

  function automatic bit m_hazard(input logic v, input logic [31:0] w);
    return v && m_vld && m_b.mr && m_b.dest != 5'd0 &&
           ((ref_uses_rs(w) && w[25:21] == m_b.dest) || (ref_uses_rt(w) && w[20:16] == m_b.dest));
  endfunction

  function automatic logic [63:0] dut_bundle();
    return {bus.out_alu_code, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
            bus.out_mem_to_reg, bus.out_alu_src_a, bus.out_alu_src_b, bus.out_j, bus.out_jr,
            bus.out_jal, bus.out_branch, bus.out_lui, bus.out_illegal,
            bus.out_rs, bus.out_rt, bus.out_dest, bus.out_imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    int          sel;
    w        = $urandom;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    sel      = $urandom_range(0, 9);
    if (sel == 0) return 32'd0;
    if (sel == 1) return w;
    if (sel == 2) begin w[31:26] = 6'h01; return w; end
    if (sel == 3) begin w[31:26] = 6'h23; return w; end
    k = $urandom_range(0, tbl.size() - 1);
    w[31:26] = tbl[k].op;
    if (tbl[k].op == 6'd0) w[5:0] = tbl[k].fn;
    return w;
  endfunction

  // One cycle: drive at the falling edge, check ready, advance the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic r, input logic f);
    bit hz;
    bit rdy;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = r;
    bus.flush     = f;
    hz  = m_hazard(v, w);
    rdy = f || ((!m_vld || r) && !hz);
    #1;
    last_rdy = bus.in_ready;
    check("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    if (f) m_vld = 0;
    else if (hz && r) begin
      m_vld = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (v && rdy) begin
      m_vld = 1;
      m_b   = ref_decode(w, 1'b1);
      m_pc  = pc;
    end else if (r) m_vld = 0;
    @(negedge clk);
    check("out_valid", bus.out_valid, m_vld);
    check("stall_cnt", stall_cnt, m_cnt);
    if (m_vld) begin
      check("bundle", dut_bundle(), m_b);
      check("out_pc", bus.out_pc, m_pc);
    end
  endtask

  initial begin
    add_ent(6'h00, 6'h20, 5'b00000, C_RR); add_ent(6'h00, 6'h21, 5'b00000, C_RR);
    add_ent(6'h00, 6'h22, 5'b00101, C_RR); add_ent(6'h00, 6'h23, 5'b00101, C_RR);
    add_ent(6'h00, 6'h24, 5'b00001, C_RR); add_ent(6'h00, 6'h25, 5'b00011, C_RR);
    add_ent(6'h00, 6'h26, 5'b00010, C_RR); add_ent(6'h00, 6'h27, 5'b00100, C_RR);
    add_ent(6'h00, 6'h2A, 5'b10011, C_RR); add_ent(6'h00, 6'h2B, 5'b10100, C_RR);
    add_ent(6'h00, 6'h04, 5'b10000, C_RR); add_ent(6'h00, 6'h06, 5'b10001, C_RR);
    add_ent(6'h00, 6'h07, 5'b10010, C_RR); add_ent(6'h00, 6'h00, 5'b10000, C_SH);
    add_ent(6'h00, 6'h02, 5'b10001, C_SH); add_ent(6'h00, 6'h03, 5'b10010, C_SH);
    add_ent(6'h00, 6'h08, 5'b01001, C_JR);
    add_ent(6'h08, 6'h00, 5'b00000, C_IS); add_ent(6'h09, 6'h00, 5'b00000, C_IS);
    add_ent(6'h0A, 6'h00, 5'b10011, C_IS); add_ent(6'h0B, 6'h00, 5'b10100, C_IS);
    add_ent(6'h0C, 6'h00, 5'b00110, C_IZ); add_ent(6'h0D, 6'h00, 5'b01000, C_IZ);
    add_ent(6'h0E, 6'h00, 5'b00111, C_IZ); add_ent(6'h23, 6'h00, 5'b00000, C_LW);
    add_ent(6'h2B, 6'h00, 5'b00000, C_SW); add_ent(6'h04, 6'h00, 5'b01010, C_BR);
    add_ent(6'h05, 6'h00, 5'b01011, C_BR); add_ent(6'h06, 6'h00, 5'b01110, C_BR);
    add_ent(6'h07, 6'h00, 5'b01101, C_BR); add_ent(6'h02, 6'h00, 5'b00000, C_J);
    add_ent(6'h03, 6'h00, 5'b00000, C_JAL); add_ent(6'h0F, 6'h00, 5'b10101, C_LUI);

    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0; bus.flush = 0;
    bus2.in_valid = 0; bus2.in_instr = 0; bus2.in_pc = 0; bus2.out_ready = 0; bus2.flush = 0;
    m_vld = 0; m_b = '0; m_pc = 0; m_cnt = 0; last_rdy = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_cnt", stall_cnt, 16'd0);
    check("rst_bundle", dut_bundle(), 64'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    rst_n = 1'b1;

    step(1, 32'h2008FFFF, 32'h100, 1, 0);
    check("addi_valid", bus.out_valid, 1'b1);
    check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    check("addi_dest", bus.out_dest, 5'd8);
    check("addi_srcb", bus.out_alu_src_b, 1'b1);
    check("addi_alu", bus.out_alu_code, 5'b00000);

    step(1, 32'h8D090000, 32'h104, 1, 0);
    step(1, 32'h01295020, 32'h108, 1, 0);
    check("lu_in_ready", last_rdy, 1'b0);
    check("lu_bubble", bus.out_valid, 1'b0);
    check("lu_cnt", stall_cnt, 16'd1);
    step(1, 32'h01295020, 32'h108, 1, 0);
    check("lu_add_valid", bus.out_valid, 1'b1);
    check("lu_add_dest", bus.out_dest, 5'd10);

    step(1, 32'h354B1234, 32'h10C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h2008FFFF, 32'h110, 0, 0);
      check("hold_ready", last_rdy, 1'b0);
      check("hold_imm", bus.out_imm, 32'h00001234);
    end
    step(1, 32'h2008FFFF, 32'h110, 1, 0);
    check("release_pc", bus.out_pc, 32'h110);

    step(1, 32'h354B1234, 32'h114, 0, 1);
    check("flush_ready", last_rdy, 1'b1);
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_cnt", stall_cnt, 16'd1);

    step(1, 32'h8D090000, 32'h118, 1, 0);
    step(1, 32'h01295020, 32'h11C, 0, 0);
    check("luhold_cnt", stall_cnt, 16'd1);
    check("luhold_mr", bus.out_mem_read, 1'b1);
    step(1, 32'h01295020, 32'h11C, 1, 0);
    check("lu2_cnt", stall_cnt, 16'd2);
    step(1, 32'h01295020, 32'h11C, 1, 0);

    step(1, 32'h04110004, 32'h120, 1, 0);
    check("regimm_ill", bus.out_illegal, 1'b1);
    check("regimm_rw", bus.out_reg_write, 1'b0);
    step(1, 32'h04010004, 32'h124, 1, 0);
    check("bgez_br", bus.out_branch, 1'b1);
    check("bgez_alu", bus.out_alu_code, 5'b01100);
    check("bgez_imm", bus.out_imm, 32'h10);
    step(1, 32'h0C000010, 32'h128, 1, 0);
    check("jal_flag", bus.out_jal, 1'b1);
    check("jal_dest", bus.out_dest, 5'd31);
    check("jal_imm", bus.out_imm, 32'h40);
    step(1, 32'h00000000, 32'h12C, 1, 0);
    check("nop_ill", bus.out_illegal, 1'b0);
    check("nop_rw", bus.out_reg_write, 1'b0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] w;
      w = rand_instr();
      step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    step(1, 32'h8D090000, 32'h200, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 0; m_cnt = 0; m_b = '0; m_pc = 0;
    bus.in_valid = 0;

    bus2.in_valid = 1; bus2.in_instr = 32'h8D290000; bus2.in_pc = 32'h300; bus2.out_ready = 1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("sat_cnt", stall_cnt2, 2'b11);
    bus2.in_instr = 32'h0C000010;
    @(posedge clk);
    @(negedge clk);
    check("jal2_valid", bus2.out_valid, 1'b1);
    check("jal2_ill", bus2.out_illegal, 1'b1);
    check("jal2_jal", bus2.out_jal, 1'b0);
    check("jal2_rw", bus2.out_reg_write, 1'b0);
    check("jal2_dest", bus2.out_dest, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
